scr1_dmem_tcm_resp: RTL and testbench
=====================================

SCR1_DMEM_TCM_RESP -- requirements
Module: scr1_dmem_tcm_resp

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two, >=4).
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0001_0000, byte base address of the window (aligned to 4*DEPTH_WORDS).
REQ-003 SHALL provide parameter WAIT_STATES, default 0, extra cycles between acceptance and response (0..7).
REQ-004 Ports (one clock; reset is synchronous and active-low):
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  synchronous active-low reset
  dmem_req  in  1  request valid from initiator
  dmem_cmd  in  1  type_scr1_mem_cmd_e: RD=0, WR=1
  dmem_width  in  2  type_scr1_mem_width_e: BYTE=0, HWORD=1, WORD=2
  dmem_addr  in  32  byte address
  dmem_wdata  in  32  store data, right-aligned (byte in [7:0], hword in [15:0])
  dmem_req_ack  out  1  request accepted this cycle when high with dmem_req
  dmem_rdata  out  32  load data, right-aligned
  dmem_resp  out  2  type_scr1_mem_resp_e: IDLE=0, RDY_OK=1, RDY_ER=2

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-006 dmem_req_ack SHALL be 1 exactly when state==IDLE (combinational from state only).
REQ-007 Acceptance = dmem_req & dmem_req_ack; on acceptance SHALL latch cmd, width, addr, wdata and error flag.
REQ-008 IDLE -> RESP on acceptance when WAIT_STATES==0; IDLE -> WAIT (counter loaded WAIT_STATES-1) otherwise.
REQ-009 WAIT SHALL decrement counter each cycle; WAIT -> RESP when counter==0.
REQ-010 RESP SHALL last exactly one cycle, then -> IDLE unconditionally; no acceptance during WAIT or RESP.
REQ-011 Latency: request accepted in cycle N SHALL respond (dmem_resp != IDLE) in cycle N+1+WAIT_STATES only.
REQ-012 dmem_resp SHALL be IDLE in IDLE and WAIT states; RDY_OK or RDY_ER in RESP.
REQ-013 Error flag SHALL be set when addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), or HWORD with addr[0]=1, or WORD with addr[1:0]!=0, or width==3.
REQ-014 Errored request SHALL respond RDY_ER, dmem_rdata=0, and SHALL NOT modify storage.
REQ-015 Word index = addr[log2(DEPTH_WORDS)+1:2] relative to BASE_ADDR; byte lane = addr[1:0].
REQ-016 Write byte enables: BYTE -> 1 lane at addr[1:0]; HWORD -> lanes addr[1]*2..+1; WORD -> all 4.
REQ-017 Write data SHALL be wdata shifted left by 8*addr[1:0]; only enabled lanes updated, in the RESP cycle.
REQ-018 Read data SHALL be storage word (as of RESP cycle) shifted right by 8*addr[1:0], zero-filled; upper bits beyond width SHALL be zero (BYTE: [31:8]=0, HWORD: [31:16]=0).
REQ-019 dmem_rdata SHALL be 0 whenever dmem_resp != RDY_OK, and for successful writes.
REQ-020 Inputs SHALL be ignored outside the acceptance cycle; changes during WAIT/RESP SHALL not affect the response.

Reset
REQ-021 When rst_n=0 at a rising edge: state=IDLE, counter=0, latched fields=0; dmem_resp=IDLE, dmem_rdata=0 the following cycle.
REQ-022 Reset mid-transaction (WAIT or RESP) SHALL abort it; no response issued, pending write not performed.
REQ-023 Storage contents SHALL NOT be reset.

Verification
REQ-024 WAIT_STATES=0: SW addr BASE+0x10 wdata 32'hDEADBEEF accepted cycle N -> RDY_OK in N+1; LW same addr -> rdata 32'hDEADBEEF.
REQ-025 After REQ-024: SB BASE+0x11 wdata 32'h55 then LW BASE+0x10 -> 32'hDEAD55EF; LBU BASE+0x13 -> 32'h000000DE; LH BASE+0x12 -> 32'h0000DEAD.
REQ-026 LW BASE+0x2 -> RDY_ER, rdata 0; SW BASE+4*DEPTH_WORDS -> RDY_ER, and later LW BASE+0 unchanged.
REQ-027 WAIT_STATES=3: request accepted cycle N -> dmem_req_ack low N+1..N+4, resp IDLE N+1..N+3, RDY_OK N+4, req_ack high N+5.
REQ-028 WAIT_STATES=3: SW accepted, rst_n low in cycle N+2 -> no response, state IDLE, later LW shows old data.
REQ-029 dmem_req held high continuously -> accepts every 2+WAIT_STATES cycles, exactly one response per acceptance.

Source files
------------

// File: rtl/scr1_dmem_tcm_resp.sv
// Tightly-coupled data memory responder for the SCR1 dmem port.
// A request is accepted only in IDLE. After WAIT_STATES extra cycles the
// response is produced for exactly one cycle. Errored requests never touch
// storage.
module scr1_dmem_tcm_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_req_ack,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_resp
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_MASK = 32'(4 * DEPTH_WORDS - 1);
    localparam logic [2:0]  WS_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [1:0] RESP_IDLE   = 2'd0;
    localparam logic [1:0] RESP_RDY_OK = 2'd1;
    localparam logic [1:0] RESP_RDY_ER = 2'd2;

    localparam logic [1:0] W_BYTE  = 2'd0;
    localparam logic [1:0] W_HWORD = 2'd1;
    localparam logic [1:0] W_WORD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e            state;
    state_e            state_next;
    logic [2:0]        cnt;
    logic [2:0]        cnt_next;

    logic              cmd_q;
    logic [1:0]        width_q;
    // Only the in-window offset is kept; the range check is resolved at acceptance.
    logic [IDX_W+1:0]  off_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    logic              accept;
    logic              in_window;
    logic              misaligned;
    logic              req_err;

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic [3:0]        be;
    logic [31:0]       wdata_sh;
    logic [31:0]       rd_sh;

    logic [31:0]       mem [DEPTH_WORDS];

    assign accept = dmem_req & (state == ST_IDLE);

    // Request error classification: window range, alignment and width legality.
    always_comb begin
        in_window  = ((dmem_addr & ~WIN_MASK) == BASE_ADDR);
        misaligned = 1'b0;
        case (dmem_width)
            W_BYTE:  misaligned = 1'b0;
            W_HWORD: misaligned = dmem_addr[0];
            W_WORD:  misaligned = (dmem_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        req_err = ~in_window | misaligned;
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the request on acceptance; held stable until the next acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q   <= 1'b0;
            width_q <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cmd_q   <= dmem_cmd;
            width_q <= dmem_width;
            off_q   <= dmem_addr[IDX_W+1:0];
            wdata_q <= dmem_wdata;
            err_q   <= req_err;
        end
    end

    // Lane alignment of the latched request against the addressed word.
    always_comb begin
        idx      = off_q[IDX_W+1:2];
        lane     = off_q[1:0];
        word     = mem[idx];
        wdata_sh = wdata_q << {lane, 3'b000};
        rd_sh    = word >> {lane, 3'b000};
        case (width_q)
            W_BYTE:  be = 4'b0001 << lane;
            W_HWORD: be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    // Storage update in the response cycle; a reset in that cycle cancels it.
    always_ff @(posedge clk) begin
        if (rst_n && (state == ST_RESP) && !err_q && cmd_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    // Handshake and response outputs, decoded from state.
    always_comb begin
        dmem_req_ack = (state == ST_IDLE);
        dmem_resp    = RESP_IDLE;
        dmem_rdata   = '0;
        if (state == ST_RESP) begin
            if (err_q) begin
                dmem_resp = RESP_RDY_ER;
            end else begin
                dmem_resp = RESP_RDY_OK;
                if (!cmd_q) begin
                    case (width_q)
                        W_BYTE:  dmem_rdata = {24'd0, rd_sh[7:0]};
                        W_HWORD: dmem_rdata = {16'd0, rd_sh[15:0]};
                        default: dmem_rdata = rd_sh;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_scr1_dmem_tcm_resp.sv
// Bench for scr1_dmem_tcm_resp: two instances (0 and 3 wait states) checked
// against a byte-addressed reference memory model.
module tb_scr1_dmem_tcm_resp;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int unsigned WS0   = 0;
    localparam int unsigned WS1   = 3;

    logic             clk;
    logic [1:0]       rst_n_v;
    logic [1:0]       req_v;
    logic [1:0]       cmd_v;
    logic [1:0][1:0]  width_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] wdata_v;
    logic [1:0]       ack_v;
    logic [1:0][31:0] rdata_v;
    logic [1:0][1:0]  resp_v;

    int checks;
    int passes;

    logic [7:0] mm [2][4*DEPTH];

    scr1_dmem_tcm_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .dmem_req(req_v[0]), .dmem_cmd(cmd_v[0]),
        .dmem_width(width_v[0]), .dmem_addr(addr_v[0]), .dmem_wdata(wdata_v[0]),
        .dmem_req_ack(ack_v[0]), .dmem_rdata(rdata_v[0]), .dmem_resp(resp_v[0])
    );

    scr1_dmem_tcm_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .dmem_req(req_v[1]), .dmem_cmd(cmd_v[1]),
        .dmem_width(width_v[1]), .dmem_addr(addr_v[1]), .dmem_wdata(wdata_v[1]),
        .dmem_req_ack(ack_v[1]), .dmem_rdata(rdata_v[1]), .dmem_resp(resp_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? int'(WS0) : int'(WS1);
    endfunction

    // Reference: a request fails if outside the window, misaligned for its size, or width 3.
    function automatic logic model_err(input logic [1:0] w, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 4 * DEPTH) return 1'b1;
        if (w == 2'd3) return 1'b1;
        if (w == 2'd1 && (a % 2) != 0) return 1'b1;
        if (w == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference access: little-endian bytes, reads assembled from 1/2/4 bytes.
    task automatic model_op(input int d, input logic c, input logic [1:0] w, input logic [31:0] a,
                            input logic [31:0] wd, output logic [1:0] er, output logic [31:0] erd);
        int unsigned off;
        int unsigned n;
        erd = '0;
        if (model_err(w, a)) begin
            er = 2'd2;
        end else begin
            er  = 2'd1;
            off = a - BASE;
            n   = 1 << w;
            for (int b = 0; b < int'(n); b++) begin
                if (c) mm[d][off + b] = wd[8*b +: 8];
                else   erd[8*b +: 8] = mm[d][off + b];
            end
        end
    endtask

    // Drives one request, scrambles inputs after acceptance, and reports what came back.
    task automatic txn(input int d, input logic c, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] wd, output logic [1:0] r, output logic [31:0] rd,
                       output int lat, output int bad_ack);
        int guard;
        r = '0; rd = '0; lat = -1; bad_ack = 0;
        @(negedge clk);
        cmd_v[d] = c; width_v[d] = w; addr_v[d] = a; wdata_v[d] = wd; req_v[d] = 1'b1;
        guard = 0;
        while (!ack_v[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ack_v[d]) begin
            req_v[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        cmd_v[d] = 1'($urandom); width_v[d] = 2'($urandom);
        addr_v[d] = $urandom; wdata_v[d] = $urandom;
        for (int k = 1; k <= 20; k++) begin
            if (ack_v[d]) bad_ack++;
            if (resp_v[d] != 2'd0) begin
                r = resp_v[d]; rd = rdata_v[d]; lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!ack_v[d] || resp_v[d] != 2'd0) bad_ack++;
    endtask

    task automatic test_reset();
        rst_n_v = 2'b00; req_v = '0; cmd_v = '0; width_v = '0; addr_v = '0; wdata_v = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_v = 2'b11;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (resp_v[d] !== 2'd0) $display("FAIL reset_resp dut%0d got %0d want 0", d, resp_v[d]);
            else passes++;
            checks++;
            if (rdata_v[d] !== 32'd0) $display("FAIL reset_rdata dut%0d got %h want 0", d, rdata_v[d]);
            else passes++;
            checks++;
            if (ack_v[d] !== 1'b1) $display("FAIL reset_ack dut%0d got %b want 1", d, ack_v[d]);
            else passes++;
        end
    endtask

    task automatic test_fill(input int d);
        logic [1:0] r, er;
        logic [31:0] rd, erd, wd;
        int lat, bad;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wd = $urandom;
            model_op(d, 1'b1, 2'd2, BASE + 32'(4 * i), wd, er, erd);
            txn(d, 1'b1, 2'd2, BASE + 32'(4 * i), wd, r, rd, lat, bad);
            checks++;
            if (r !== er || rd !== erd || lat != 1 + ws_of(d) || bad != 0)
                $display("FAIL fill dut%0d word %0d got resp=%0d rdata=%h lat=%0d badack=%0d want resp=%0d rdata=%h lat=%0d badack=0",
                         d, i, r, rd, lat, bad, er, erd, 1 + ws_of(d));
            else passes++;
        end
    endtask

    typedef struct {
        logic        c;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  er;
        logic [31:0] erd;
        logic        use_model;
    } step_t;

    task automatic test_directed_ws0();
        step_t steps[$];
        logic [1:0] r, mr;
        logic [31:0] rd, mrd;
        int lat, bad;
        steps.push_back('{1'b1, 2'd2, BASE + 32'h10, 32'hDEADBEEF, 2'd1, 32'h0,        1'b0});
        steps.push_back('{1'b0, 2'd2, BASE + 32'h10, 32'h0,        2'd1, 32'hDEADBEEF, 1'b0});
        steps.push_back('{1'b1, 2'd0, BASE + 32'h11, 32'h55,       2'd1, 32'h0,        1'b0});
        steps.push_back('{1'b0, 2'd2, BASE + 32'h10, 32'h0,        2'd1, 32'hDEAD55EF, 1'b0});
        steps.push_back('{1'b0, 2'd0, BASE + 32'h13, 32'h0,        2'd1, 32'h000000DE, 1'b0});
        steps.push_back('{1'b0, 2'd1, BASE + 32'h12, 32'h0,        2'd1, 32'h0000DEAD, 1'b0});
        steps.push_back('{1'b0, 2'd2, BASE + 32'h2,  32'h0,        2'd2, 32'h0,        1'b0});
        steps.push_back('{1'b0, 2'd2, BASE,          32'h0,        2'd1, 32'h0,        1'b1});
        steps.push_back('{1'b1, 2'd2, BASE + 32'(4*DEPTH), 32'h12345678, 2'd2, 32'h0,  1'b0});
        steps.push_back('{1'b0, 2'd2, BASE,          32'h0,        2'd1, 32'h0,        1'b1});
        steps.push_back('{1'b0, 2'd3, BASE + 32'h20, 32'h0,        2'd2, 32'h0,        1'b0});
        steps.push_back('{1'b1, 2'd1, BASE + 32'h21, 32'hFFFF,     2'd2, 32'h0,        1'b0});
        foreach (steps[i]) begin
            model_op(0, steps[i].c, steps[i].w, steps[i].a, steps[i].wd, mr, mrd);
            if (steps[i].use_model) begin
                steps[i].er  = mr;
                steps[i].erd = mrd;
            end
            txn(0, steps[i].c, steps[i].w, steps[i].a, steps[i].wd, r, rd, lat, bad);
            checks++;
            if (r !== steps[i].er || rd !== steps[i].erd || lat != 1 || bad != 0)
                $display("FAIL directed step %0d got resp=%0d rdata=%h lat=%0d badack=%0d want resp=%0d rdata=%h lat=1 badack=0",
                         i, r, rd, lat, bad, steps[i].er, steps[i].erd);
            else passes++;
        end
    endtask

    task automatic test_latency_ws3();
        logic [1:0] r, er;
        logic [31:0] rd, erd;
        int lat, bad;
        model_op(1, 1'b1, 2'd2, BASE + 32'h8, 32'hCAFEF00D, er, erd);
        txn(1, 1'b1, 2'd2, BASE + 32'h8, 32'hCAFEF00D, r, rd, lat, bad);
        checks++;
        if (lat != 4) $display("FAIL latency_ws3 got %0d want 4", lat);
        else passes++;
        checks++;
        if (bad != 0) $display("FAIL ack_ws3 bad_cycles got %0d want 0", bad);
        else passes++;
        model_op(1, 1'b0, 2'd2, BASE + 32'h8, 32'h0, er, erd);
        txn(1, 1'b0, 2'd2, BASE + 32'h8, 32'h0, r, rd, lat, bad);
        checks++;
        if (r !== er || rd !== erd) $display("FAIL readback_ws3 got resp=%0d rdata=%h want resp=%0d rdata=%h", r, rd, er, erd);
        else passes++;
    endtask

    task automatic test_random(input int d, input int n);
        logic [1:0] r, er, w;
        logic [31:0] rd, erd, a, wd;
        logic c;
        int lat, bad, sel;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 85)      a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (sel < 92) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else               a = BASE - 32'($urandom_range(1, 64));
            sel = $urandom_range(0, 19);
            w = (sel < 6) ? 2'd0 : (sel < 12) ? 2'd1 : (sel < 19) ? 2'd2 : 2'd3;
            if (w != 2'd3 && $urandom_range(0, 1) == 1) a = a & ~((32'd1 << w) - 32'd1);
            c  = 1'($urandom);
            wd = $urandom;
            model_op(d, c, w, a, wd, er, erd);
            txn(d, c, w, a, wd, r, rd, lat, bad);
            checks++;
            if (r !== er || rd !== erd || lat != 1 + ws_of(d) || bad != 0)
                $display("FAIL random dut%0d #%0d cmd=%0d w=%0d a=%h got resp=%0d rdata=%h lat=%0d badack=%0d want resp=%0d rdata=%h lat=%0d",
                         d, i, c, w, a, r, rd, lat, bad, er, erd, 1 + ws_of(d));
            else passes++;
        end
    endtask

    task automatic test_reset_abort();
        logic [1:0] r, er;
        logic [31:0] rd, erd;
        int lat, bad, seen, guard;
        @(negedge clk);
        cmd_v[1] = 1'b1; width_v[1] = 2'd2; addr_v[1] = BASE + 32'h20; wdata_v[1] = 32'hA5A5_5A5A; req_v[1] = 1'b1;
        guard = 0;
        while (!ack_v[1] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!ack_v[1]) $display("FAIL abort_accept got ack=0 want 1");
        else passes++;
        @(posedge clk); #1;
        req_v[1] = 1'b0;
        seen = (resp_v[1] != 2'd0) ? 1 : 0;
        @(posedge clk); #1;
        rst_n_v[1] = 1'b0;
        if (resp_v[1] != 2'd0) seen++;
        @(posedge clk); #1;
        rst_n_v[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (resp_v[1] != 2'd0) seen++;
            if (k < 5) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (seen != 0) $display("FAIL abort_no_resp got %0d response cycles want 0", seen);
        else passes++;
        checks++;
        if (ack_v[1] !== 1'b1) $display("FAIL abort_idle got ack=%b want 1", ack_v[1]);
        else passes++;
        model_op(1, 1'b0, 2'd2, BASE + 32'h20, 32'h0, er, erd);
        txn(1, 1'b0, 2'd2, BASE + 32'h20, 32'h0, r, rd, lat, bad);
        checks++;
        if (r !== er || rd !== erd) $display("FAIL abort_old_data got resp=%0d rdata=%h want resp=%0d rdata=%h", r, rd, er, erd);
        else passes++;
    endtask

    task automatic test_back_to_back(input int d);
        int acc_q[$];
        int resp_q[$];
        int bad_data, bad_gap, bad_lat;
        logic [1:0] er;
        logic [31:0] erd;
        model_op(d, 1'b0, 2'd2, BASE + 32'h40, 32'h0, er, erd);
        bad_data = 0; bad_gap = 0; bad_lat = 0;
        @(posedge clk); #1;
        cmd_v[d] = 1'b0; width_v[d] = 2'd2; addr_v[d] = BASE + 32'h40; req_v[d] = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc == 40) req_v[d] = 1'b0;
            if (ack_v[d] && req_v[d]) acc_q.push_back(cyc);
            if (resp_v[d] != 2'd0) begin
                resp_q.push_back(cyc);
                if (resp_v[d] !== er || rdata_v[d] !== erd) bad_data++;
            end
            @(posedge clk); #1;
        end
        for (int i = 1; i < acc_q.size(); i++)
            if (acc_q[i] - acc_q[i-1] != 2 + ws_of(d)) bad_gap++;
        checks++;
        if (acc_q.size() < 2 || bad_gap != 0)
            $display("FAIL b2b_spacing dut%0d accepts=%0d bad_gaps=%0d want gap %0d", d, acc_q.size(), bad_gap, 2 + ws_of(d));
        else passes++;
        checks++;
        if (resp_q.size() != acc_q.size())
            $display("FAIL b2b_count dut%0d got %0d responses want %0d", d, resp_q.size(), acc_q.size());
        else passes++;
        for (int i = 0; i < resp_q.size() && i < acc_q.size(); i++)
            if (resp_q[i] != acc_q[i] + 1 + ws_of(d)) bad_lat++;
        checks++;
        if (bad_lat != 0 || bad_data != 0)
            $display("FAIL b2b_resp dut%0d bad_latency=%0d bad_data=%0d want 0 and 0", d, bad_lat, bad_data);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_fill(0);
        test_fill(1);
        test_directed_ws0();
        test_latency_ws3();
        test_random(0, 150);
        test_random(1, 150);
        test_reset_abort();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
